// File: rtl/mino_pkg.sv
// Shared definitions for the minority-detector sweep checker: FSM state
// encodings, sweep size, settle-counter width and the golden minority function.
package mino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int         NUM_VEC  = 8;
    localparam int         SETTLE_W = 4;
    localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

    // Output is 1 when fewer than two of the three inputs are high.
    function automatic logic mino_golden(input logic [2:0] v);
        return ~((v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]));
    endfunction

endpackage

// File: rtl/mino_settle_cnt.sv
// Loadable down-counter with a zero flag; times how long each stimulus
// vector is held before its response is sampled.
module mino_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mino_sweep_checker.sv
// Drives all eight {x,y,z} vectors into a minority detector, checks each response
// against the golden function and reports pass/fail. MINO_FIRST_FAIL_CAPTURE_EN adds first-failure capture.
module mino_sweep_checker
    import mino_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       fail_vec,
    output logic             fail_seen
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_vec;
    logic [CNT_W-1:0] r_err;
    logic             r_pass;
    logic             r_busy;
    logic             r_done;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_start_ok;
    logic             w_mismatch;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_mismatch = (r_state == ST_SAMPLE) && (resp != mino_golden(r_vec));

    mino_settle_cnt #(
        .W (SETTLE_W)
    ) u_settle_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next     = ST_SETTLE;
                    w_cnt_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_next = ST_SAMPLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (r_vec == LAST_VEC) begin
                    w_next = ST_DONE;
                end else begin
                    w_next     = ST_SETTLE;
                    w_cnt_load = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Sweep datapath. The DONE-cycle results are registered on the way out,
    // so done/pass/busy change on the edge that returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec  <= '0;
            r_err  <= '0;
            r_pass <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_start_ok) begin
                r_vec  <= '0;
                r_err  <= '0;
                r_pass <= 1'b0;
                r_busy <= 1'b1;
            end
            if (r_state == ST_SAMPLE) begin
                if (w_mismatch && (r_err != '1)) begin
                    r_err <= r_err + 1'b1;
                end
                if (r_vec != LAST_VEC) begin
                    r_vec <= r_vec + 1'b1;
                end
            end
            if (r_state == ST_DONE) begin
                r_pass <= (r_err == '0);
                r_busy <= 1'b0;
                r_vec  <= '0;
            end
        end
    end

`ifdef MINO_FIRST_FAIL_CAPTURE_EN
    logic [2:0] r_fail_vec;
    logic       r_fail_seen;

    // Only the first mismatch of a sweep is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_vec  <= '0;
            r_fail_seen <= 1'b0;
        end else if (w_start_ok) begin
            r_fail_vec  <= '0;
            r_fail_seen <= 1'b0;
        end else if (w_mismatch && !r_fail_seen) begin
            r_fail_vec  <= r_vec;
            r_fail_seen <= 1'b1;
        end
    end

    assign fail_vec  = r_fail_vec;
    assign fail_seen = r_fail_seen;
`else
    assign fail_vec  = 3'b000;
    assign fail_seen = 1'b0;
`endif

    assign x       = r_vec[2];
    assign y       = r_vec[1];
    assign z       = r_vec[0];
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;

endmodule

// File: tb/tb_mino_sweep_checker.sv
// Scoreboard bench for mino_sweep_checker: directed sweeps with ideal, stuck-at-0
// and majority responders, extra starts, mid-sweep reset and settle-length extremes.
module tb_mino_sweep_checker;

    localparam int S_MAIN   = 2;
    localparam int LAT_MAIN = 1 + 8 * (S_MAIN + 1);

    typedef struct {
        logic [3:0] err;
        logic       pass;
        logic [2:0] fvec;
        logic       fseen;
        int         startCyc;
    } exp_t;

    exp_t sbQ[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic startAlt = 1'b0;
    int   mode  = 0;

    logic       resp, x, y, z, busy, done, pass, fseen;
    logic [3:0] errCnt;
    logic [2:0] fvec;

    logic       resp1, x1, y1, z1, busy1, done1, pass1, fseen1;
    logic [3:0] errCnt1;
    logic [2:0] fvec1;

    logic       resp15, x15, y15, z15, busy15, done15, pass15, fseen15;
    logic [3:0] errCnt15;
    logic [2:0] fvec15;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder model: 0 ideal minority, 1 stuck at 0, 2 majority.
    function automatic logic respModel(input int m, input logic a, input logic b, input logic c);
        logic [1:0] ones;
        ones = {1'b0, a} + {1'b0, b} + {1'b0, c};
        case (m)
            0:       return (ones < 2'd2);
            1:       return 1'b0;
            default: return (ones >= 2'd2);
        endcase
    endfunction

    assign resp   = respModel(mode, x, y, z);
    assign resp1  = respModel(0, x1, y1, z1);
    assign resp15 = respModel(0, x15, y15, z15);

    mino_sweep_checker #(.SETTLE_CYC(S_MAIN), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .resp(resp),
        .x(x), .y(y), .z(z), .busy(busy), .done(done), .pass(pass),
        .err_cnt(errCnt), .fail_vec(fvec), .fail_seen(fseen)
    );

    mino_sweep_checker #(.SETTLE_CYC(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(startAlt), .resp(resp1),
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(errCnt1), .fail_vec(fvec1), .fail_seen(fseen1)
    );

    mino_sweep_checker #(.SETTLE_CYC(15), .CNT_W(4)) dut15 (
        .clk(clk), .rst(rst), .start(startAlt), .resp(resp15),
        .x(x15), .y(y15), .z(z15), .busy(busy15), .done(done15), .pass(pass15),
        .err_cnt(errCnt15), .fail_vec(fvec15), .fail_seen(fseen15)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected sweep outcome for a responder mode, built by walking all vectors.
    function automatic exp_t computeExpected(input int m);
        exp_t e;
        logic [2:0] v;
        logic gold;
        e.err = 4'd0; e.pass = 1'b0; e.fvec = 3'd0; e.fseen = 1'b0; e.startCyc = 0;
        for (int i = 0; i < 8; i++) begin
            v    = 3'(i);
            gold = !((v[2] && v[1]) || (v[1] && v[0]) || (v[2] && v[0]));
            if (respModel(m, v[2], v[1], v[0]) != gold) begin
`ifdef MINO_FIRST_FAIL_CAPTURE_EN
                if (!e.fseen) begin
                    e.fvec  = v;
                    e.fseen = 1'b1;
                end
`endif
                e.err = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_xyz"},   32'({x, y, z}), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy),      32'd0);
        checkOutput({tag, "_done"},  32'(done),      32'd0);
        checkOutput({tag, "_pass"},  32'(pass),      32'd0);
        checkOutput({tag, "_err"},   32'(errCnt),    32'd0);
        checkOutput({tag, "_fvec"},  32'(fvec),      32'd0);
        checkOutput({tag, "_fseen"}, 32'(fseen),     32'd0);
    endtask

    // Scoreboard consumer: every done pulse pops one expected sweep result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("sbUnexpectedDone", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("latency",   32'(cyc - e.startCyc), 32'(LAT_MAIN));
                checkOutput("errCnt",    32'(errCnt), 32'(e.err));
                checkOutput("pass",      32'(pass),   32'(e.pass));
                checkOutput("busyAtDone", 32'(busy),  32'd0);
                checkOutput("failVec",   32'(fvec),   32'(e.fvec));
                checkOutput("failSeen",  32'(fseen),  32'(e.fseen));
            end
        end
    end

    // Launch one sweep on the main instance and follow it until done.
    task automatic applyStimulus(input int m, input bit chkVec, input bit extras);
        exp_t e;
        int k;
        bit seen;
        mode  = m;
        e     = computeExpected(m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e.startCyc = cyc;
        sbQ.push_back(e);
        k    = 0;
        seen = 1'b0;
        while (k <= LAT_MAIN + 10) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (chkVec && k < 8 * (S_MAIN + 1)) begin
                checkOutput($sformatf("vec_k%0d", k), 32'({x, y, z}), 32'(k / (S_MAIN + 1)));
                checkOutput($sformatf("busy_k%0d", k), 32'(busy), 32'd1);
            end
            start = (extras && (k == 5 || k == 12));
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        checkOutput("doneSeen", 32'(seen), 32'd1);
    endtask

    initial begin
        int d1, d15, s0;
        bit sawDone;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] ideal sweep");
        applyStimulus(0, 1'b1, 1'b0);
        repeat (2) @(posedge clk); #1;
        checkOutput("passHeld", 32'(pass), 32'd1);

        $display("[TB] stuck-at-0 responder");
        applyStimulus(1, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;

        $display("[TB] majority responder");
        applyStimulus(2, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;

        $display("[TB] extra starts, then back-to-back sweep");
        applyStimulus(1, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        repeat (2) @(posedge clk); #1;

        $display("[TB] reset during vector 3 settle");
        mode  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("vecBeforeRst", 32'({x, y, z}), 32'd3);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        checkResetValues("midRst");
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("noDoneAfterRst", 32'(sawDone), 32'd0);
        checkOutput("busyAfterRst", 32'(busy), 32'd0);
        applyStimulus(0, 1'b1, 1'b0);
        repeat (2) @(posedge clk); #1;

        $display("[TB] settle extremes 1 and 15");
        d1  = -1;
        d15 = -1;
        startAlt = 1'b1;
        @(posedge clk); #1;
        startAlt = 1'b0;
        s0 = cyc;
        for (int i = 0; i < 200 && (d1 < 0 || d15 < 0); i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1 && d1 < 0) begin
                d1 = cyc - s0;
                checkOutput("pass_s1", 32'(pass1), 32'd1);
                checkOutput("err_s1", 32'(errCnt1), 32'd0);
            end
            if (done15 === 1'b1 && d15 < 0) begin
                d15 = cyc - s0;
                checkOutput("pass_s15", 32'(pass15), 32'd1);
                checkOutput("err_s15", 32'(errCnt15), 32'd0);
            end
        end
        checkOutput("latency_s1", 32'(d1), 32'd17);
        checkOutput("latency_s15", 32'(d15), 32'd129);
        checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
